// File: rtl/max_mask_finder_pkg.sv
// Shared types and constants for max_mask_finder.
package max_mask_finder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned INDEX_W       = 2;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/mask_onehot_check.sv
// Flags a 4-bit mask that has at most one bit set.
//   mask   : candidate mask
//   onehot : 1 when mask is one-hot or zero
module mask_onehot_check (
  input  logic [3:0] mask,
  output logic       onehot
);

  // Clearing the lowest set bit leaves zero only for one-hot or zero masks.
  assign onehot = ((mask & (mask - 4'd1)) == 4'd0);

endmodule

// File: rtl/max_mask_finder.sv
// Finds the largest of four unsigned operands by an MSB-first bit scan.
//   clk, rst         : clock, synchronous active-high reset
//   start            : load in1..in4 and begin a search (IDLE only)
//   in1..in4         : operands
//   busy             : search in progress (SCAN or DONE)
//   done             : one-cycle result-valid pulse
//   max_mask         : one-hot winner, bit i = in(i+1)
//   max_index        : zero-based winner index
//   max_value        : winning operand
module max_mask_finder
  import max_mask_finder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [WIDTH-1:0]   in3,
  input  logic [WIDTH-1:0]   in4,
  output logic               busy,
  output logic               done,
  output logic [3:0]         max_mask,
  output logic [INDEX_W-1:0] max_index,
  output logic [WIDTH-1:0]   max_value
);

  localparam int unsigned BIDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   ops [4];
  logic [3:0]         mask;
  logic [BIDX_W-1:0]  bit_idx;

  logic [3:0]         col;
  logic [3:0]         mask_next;
  logic               mask_onehot;
  logic               scan_exit;
  logic [3:0]         win_mask;
  logic [INDEX_W-1:0] win_index;

  always_comb begin
    col = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      col[i] = mask[i] & ops[i][bit_idx];
    end
    // An all-zero column keeps the previous candidates, so the mask never empties.
    mask_next = (col != 4'd0) ? col : mask;
  end

  mask_onehot_check u_onehot (
    .mask   (mask_next),
    .onehot (mask_onehot)
  );

  assign scan_exit = mask_onehot || (bit_idx == '0);

  // Ties resolve to the lowest index: isolate the lowest set bit, then encode it.
  always_comb begin
    win_mask  = mask_next & (~mask_next + 4'd1);
    win_index = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (win_mask[i]) begin
        win_index = INDEX_W'(i);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (scan_exit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        ops[i] <= '0;
      end
      mask      <= '0;
      bit_idx   <= '0;
      max_mask  <= '0;
      max_index <= '0;
      max_value <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ops[0]  <= in1;
            ops[1]  <= in2;
            ops[2]  <= in3;
            ops[3]  <= in4;
            mask    <= '1;
            bit_idx <= BIDX_W'(WIDTH - 1);
          end
        end
        SCAN: begin
          mask <= mask_next;
          if (scan_exit) begin
            max_mask  <= win_mask;
            max_index <= win_index;
            max_value <= ops[win_index];
          end else begin
            bit_idx <= bit_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_max_mask_finder.sv
module tb_max_mask_finder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in1, in2, in3, in4;
  logic       busy, done;
  logic [3:0] max_mask;
  logic [1:0] max_index;
  logic [7:0] max_value;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  max_mask_finder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .busy      (busy),
    .done      (done),
    .max_mask  (max_mask),
    .max_index (max_index),
    .max_value (max_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: results from the operand values, scan length from the
  // highest bit separating the maximum from the runner-up.
  bit         m_active = 0;
  int         m_acc, m_done_cyc;
  logic [3:0] m_mask, p_mask;
  logic [1:0] m_idx, p_idx;
  logic [7:0] m_val, p_val;

  task automatic model_start(input logic [7:0] a, b, c, d);
    logic [7:0] v [4];
    logic [7:0] mx, runner, x;
    int cnt, idx, scan;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    mx = 0;
    for (int i = 0; i < 4; i++) if (v[i] > mx) mx = v[i];
    idx = -1; cnt = 0;
    for (int i = 0; i < 4; i++) if (v[i] == mx) begin
      cnt++;
      if (idx < 0) idx = i;
    end
    if (cnt > 1) scan = 8;
    else begin
      runner = 0;
      for (int i = 0; i < 4; i++) if (i != idx && v[i] > runner) runner = v[i];
      x = mx ^ runner;
      scan = 8;
      for (int b2 = 0; b2 < 8; b2++) if (x[b2]) scan = 8 - b2;
    end
    if (m_active) begin
      p_mask = m_mask; p_idx = m_idx; p_val = m_val;
    end
    m_active   = 1;
    m_acc      = cyc;
    m_done_cyc = cyc + scan + 1;
    m_mask     = 4'b0001 << idx;
    m_idx      = idx[1:0];
    m_val      = mx;
  endtask

  task automatic model_reset();
    m_active = 0;
    p_mask = 0; p_idx = 0; p_val = 0;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, m_active && cyc > m_acc && cyc <= m_done_cyc);
      check("done", done, m_active && cyc == m_done_cyc);
      if (m_active && cyc >= m_done_cyc) begin
        check("mask", max_mask, m_mask);
        check("index", max_index, m_idx);
        check("value", max_value, m_val);
      end else if (!m_active || cyc <= m_acc) begin
        check("held_mask", max_mask, p_mask);
        check("held_index", max_index, p_idx);
        check("held_value", max_value, p_val);
      end
    end
  end

  int acc_lit;

  // Call at posedge+1 with the DUT idle.
  task automatic launch(input logic [7:0] a, b, c, d);
    in1 = a; in2 = b; in3 = c; in4 = d;
    start = 1;
    acc_lit = cyc;
    model_start(a, b, c, d);
    @(posedge clk); #1;
    start = 0;
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_check(input string nm, input int lat, input logic [3:0] m,
                            input logic [1:0] ix, input logic [7:0] v);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) check({nm, "_timeout"}, 0, 1);
    else begin
      check({nm, "_latency"}, cyc - acc_lit, lat);
      check({nm, "_mask"}, max_mask, m);
      check({nm, "_index"}, max_index, ix);
      check({nm, "_value"}, max_value, v);
    end
  endtask

  initial begin
    rst = 1; start = 0;
    in1 = 0; in2 = 0; in3 = 0; in4 = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mask", max_mask, 0);
    check("rst_value", max_value, 0);
    @(posedge clk); #1;

    launch(8'h10, 8'h80, 8'h20, 8'h05);
    wait_check("single", 2, 4'b0010, 2'd1, 8'h80);
    @(posedge clk); #1;

    launch(8'h3C, 8'h3C, 8'h3C, 8'h3C);
    wait_check("all_equal", 9, 4'b0001, 2'd0, 8'h3C);
    @(posedge clk); #1;

    launch(8'h0F, 8'h0F, 8'hF0, 8'hF0);
    wait_check("tie_pair", 9, 4'b0100, 2'd2, 8'hF0);
    // Start raised during the done cycle is ignored, then taken in IDLE.
    in1 = 0; in2 = 0; in3 = 0; in4 = 0; start = 1;
    @(posedge clk); #1;
    launch(8'h00, 8'h00, 8'h00, 8'h00);
    wait_check("zeros", 9, 4'b0001, 2'd0, 8'h00);
    @(posedge clk); #1;

    launch(8'hF0, 8'hF1, 8'hF2, 8'hF3);
    in1 = 8'hFF; in2 = 8'h00; in3 = 8'h00; in4 = 8'h00; start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_check("midscan_start", 9, 4'b1000, 2'd3, 8'hF3);
    @(posedge clk); #1;

    launch(8'h3C, 8'h3C, 8'h3C, 8'h3C);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    begin
      bit saw = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) saw = 1;
      end
      check("abort_no_done", saw, 0);
      check("abort_mask", max_mask, 0);
      check("abort_index", max_index, 0);
      check("abort_value", max_value, 0);
    end
    @(posedge clk); #1;

    launch(8'h01, 8'h02, 8'h03, 8'h04);
    wait_check("after_rst", 7, 4'b1000, 2'd3, 8'h04);
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
